// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit. Owns the architectural PC, issues one
//            32-bit fetch at a time over a valid/ready request/response
//            channel, holds the fetched word until decode accepts it and
//            applies jump redirects from execute, discarding any in-flight
//            response that was fetched from a stale PC.
// Ports    : clk, rst                     - clock, async active-high reset
//            imem_req_valid/ready, imem_addr   - fetch request channel
//            imem_resp_valid/ready, imem_resp_data - fetch response channel
//            inst, PC, PC_S, inst_valid/ready  - decode interface
//            redirect_valid, redirect_pc       - jump redirect from execute
//            misalign_fault                    - only with IFU_MISALIGN_CHECK_EN
// Options  : IFU_MISALIGN_CHECK_EN - when defined, a misaligned redirect
//            target raises a sticky misalign_fault and parks the unit in
//            FAULT; when undefined the low two target bits are masked.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_resp_data,
  output logic                imem_resp_ready,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] PC,
  output logic [DATA_LEN-1:0] PC_S,
  output logic                inst_valid,
  input  logic                inst_ready,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic                misalign_fault,
`endif
  input  logic                redirect_valid,
  input  logic [DATA_LEN-1:0] redirect_pc
);

  localparam logic [DATA_LEN-1:0] c_pc_step    = DATA_LEN'(4);
  localparam logic [DATA_LEN-1:0] c_align_mask = ~DATA_LEN'(3);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    ST_FAULT = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                kill_q, kill_d;    // next response comes from a stale PC
`ifdef IFU_MISALIGN_CHECK_EN
  logic                fault_q, fault_d;
`endif

  logic                w_req_fire;
  logic [DATA_LEN-1:0] w_target;
  logic [DATA_LEN-1:0] w_pc_inc;

  assign w_req_fire = (state_q == ST_REQ) && imem_req_ready;
  assign w_pc_inc   = pc_q + c_pc_step;   // wraps modulo 2^DATA_LEN
  assign w_target   = redirect_pc & c_align_mask;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    kill_d  = kill_q;
`ifdef IFU_MISALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Redirects are ignored here; the first fetch starts next cycle.
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = w_target;
          // The request that fires this cycle still carries the old PC.
          if (w_req_fire) begin
            state_d = ST_WAIT;
            kill_d  = 1'b1;
          end
        end else if (w_req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = w_target;
        end
        if (imem_resp_valid) begin
          // A same-cycle redirect makes this response stale as well.
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d  = imem_resp_data;
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // A redirect wins over a same-cycle accept: the held word is dropped.
        if (redirect_valid) begin
          pc_d    = w_target;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          pc_d    = w_pc_inc;
          state_d = ST_REQ;
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      ST_FAULT: begin
        // Parked until reset; an outstanding response is simply absorbed.
        state_d = ST_FAULT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef IFU_MISALIGN_CHECK_EN
    if (redirect_valid && (redirect_pc[1:0] != 2'b00) &&
        ((state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_HOLD))) begin
      pc_d    = redirect_pc;
      fault_d = 1'b1;
      state_d = ST_FAULT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      kill_q  <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      kill_q  <= kill_d;
`ifdef IFU_MISALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // All outputs decode from registered state only.
  assign imem_req_valid  = (state_q == ST_REQ);
  assign imem_addr       = pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
  assign imem_resp_ready = (state_q == ST_WAIT) || (state_q == ST_FAULT);
  assign misalign_fault  = fault_q;
`else
  assign imem_resp_ready = (state_q == ST_WAIT);
`endif
  assign inst_valid      = (state_q == ST_HOLD);
  assign inst            = inst_q;
  assign PC              = pc_q;
  assign PC_S            = w_pc_inc;

endmodule
`default_nettype wire
